// File: rtl/proc_pkg.sv
// Shared types for the ROM-driven instruction sequencer.
// ROM word layout, FSM states and default sizing.
package proc_pkg;

  localparam int DEF_ADDR_W = 8;

  localparam int WORD_W    = 16;
  localparam int FRR_LSB   = 0;
  localparam int FRR_W     = 6;
  localparam int DATA_LSB  = 6;
  localparam int DATA_W    = 8;
  localparam int HALT_BIT  = 14;
  localparam int DPRST_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_DONE,
    HALT,
    ERROR
  } state_t;

  typedef struct packed {
    logic              dp_rst;
    logic              halt;
    logic [DATA_W-1:0] data;
    logic [FRR_W-1:0]  frr;
  } word_t;

  function automatic word_t decode(input logic [WORD_W-1:0] w);
    word_t d;
    d.frr    = w[FRR_LSB +: FRR_W];
    d.data   = w[DATA_LSB +: DATA_W];
    d.halt   = w[HALT_BIT];
    d.dp_rst = w[DPRST_BIT];
    return d;
  endfunction

endpackage

// File: rtl/rom_sequencer_wd_counter.sv
// Watchdog counter bounding the wait for datapath completion.
// tc flags that the next enabled increment reaches LIMIT.
module wd_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT - 1));

  // count enabled cycles, saturating at LIMIT
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rom_sequencer.sv
// Fetches 16-bit words from a synchronous ROM and issues
// them to a datapath with go / DpReset handshakes.
module rom_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              init,
  input  logic              en,
  input  logic              ifDone,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_q,
  output logic [FRR_W-1:0]  frr,
  output logic [DATA_W-1:0] Data,
  output logic              go,
  output logic              DpReset,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  state_t state;
  state_t state_n;

  word_t word;
  logic  halt_r;
  logic  rst_r;
  logic  sticky;
  logic  last;
  logic  load;
  logic  done;
  logic  restart;
  logic  wd_clr;
  logic  wd_inc;
  logic  tc;

  assign word = decode(rom_q);
  assign last = &rom_addr;

  assign busy   = (state != IDLE) &&
                  (state != HALT) &&
                  (state != ERROR);
  assign halted = (state == HALT);
  assign err    = (state == ERROR);

  wd_counter #(
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk (clk),
    .rst (Reset),
    .clr (wd_clr),
    .inc (wd_inc),
    .tc  (tc)
  );

  // state register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state and strobes; a stalled cycle changes nothing
  always_comb begin
    state_n = state;
    go      = 1'b0;
    DpReset = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    restart = 1'b0;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    if (en && !Reset) begin
      unique case (state)
        IDLE, HALT, ERROR: begin
          if (init) begin
            restart = 1'b1;
            state_n = FETCH;
          end
        end
        FETCH: begin
          state_n = LATCH;
        end
        LATCH: begin
          load    = 1'b1;
          state_n = ISSUE;
        end
        ISSUE: begin
          if (rst_r) begin
            DpReset = 1'b1;
            done    = 1'b1;
          end else begin
            go      = 1'b1;
            wd_clr  = 1'b1;
            state_n = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          wd_inc = 1'b1;
          if (ifDone || sticky) begin
            done = 1'b1;
          end else if (tc) begin
            state_n = ERROR;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
      if (done) begin
        state_n = (halt_r || last) ? HALT : FETCH;
      end
    end
  end

  // program counter, instruction fields, late-done flag
  always_ff @(posedge clk) begin
    if (Reset) begin
      rom_addr <= '0;
      frr      <= '0;
      Data     <= '0;
      halt_r   <= 1'b0;
      rst_r    <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      if (restart) begin
        rom_addr <= '0;
      end else if (done && !halt_r && !last) begin
        rom_addr <= rom_addr + 1'b1;
      end
      if (load) begin
        frr    <= word.frr;
        Data   <= word.data;
        halt_r <= word.halt;
        rst_r  <= word.dp_rst;
      end
      if (wd_clr || done) begin
        sticky <= 1'b0;
      end else if ((state == WAIT_DONE) && !en && ifDone) begin
        sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Randomized and directed checks of rom_sequencer against a
// program-walk reference model of the ROM contents.
module tb_rom_sequencer;

  localparam int AW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          Reset;
  logic          init;
  logic          en;
  logic          ifDone;
  logic          resp_done;
  logic          man_done;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_q;
  logic [5:0]    frr;
  logic [7:0]    Data;
  logic          go;
  logic          DpReset;
  logic          busy;
  logic          halted;
  logic          err;

  logic [15:0] rom [4];
  logic [17:0] obs [$];
  logic [17:0] exp_q [$];

  int errors = 0;
  int checks = 0;
  bit resp_on;
  int resp_dly;
  bit mon_on;
  int n;

  always #5 clk = ~clk;

  assign ifDone = resp_done | man_done;

  always @(posedge clk) rom_q <= rom[rom_addr];

  rom_sequencer #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .init     (init),
    .en       (en),
    .ifDone   (ifDone),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .frr      (frr),
    .Data     (Data),
    .go       (go),
    .DpReset  (DpReset),
    .busy     (busy),
    .halted   (halted),
    .err      (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mkw(input bit r,
                                      input bit h,
                                      input logic [7:0] d,
                                      input logic [5:0] f);
    return {r, h, d, f};
  endfunction

  // walk the program from address 0 as the spec describes
  task automatic build_exp(output int last_a);
    logic [15:0] w;
    logic [1:0]  aa;
    exp_q.delete();
    last_a = 0;
    for (int a = 0; a < 4; a++) begin
      w  = rom[a];
      aa = a[1:0];
      exp_q.push_back({~w[15], w[15], aa, w[5:0], w[13:6]});
      last_a = a;
      if (w[14]) break;
    end
  endtask

  // datapath model: ifDone some cycles after each go
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (go && resp_on) begin
        int d;
        d = (resp_dly == 0) ? $urandom_range(1, 4) : resp_dly;
        repeat (d) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on && (go || DpReset))
      obs.push_back({go, DpReset, rom_addr, frr, Data});
  end

  task automatic launch();
    tick();
    init = 1'b1;
    en   = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic wait_pulse(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(go || DpReset) && cnt < 200);
    chk("pulse_seen", go | DpReset, 1);
  endtask

  task automatic wait_end();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(halted || err) && c < 400);
    chk("end_seen", halted | err, 1);
  endtask

  task automatic run_prog(input bit stall, input int dly,
                          input string tag);
    int last_a;
    build_exp(last_a);
    obs.delete();
    mon_on   = 1'b1;
    resp_on  = 1'b1;
    resp_dly = dly;
    launch();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (halted || err) break;
      tick();
      en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    mon_on = 1'b0;
    en     = 1'b1;
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_addr"}, rom_addr, last_a);
    chk({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk({tag, "_instr"}, obs[i], exp_q[i]);
    chk({tag, "_stable"}, {frr, Data}, exp_q[$][13:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b1;
    init     = 1'b0;
    en       = 1'b0;
    man_done = 1'b0;
    resp_on  = 1'b0;
    resp_dly = 1;
    mon_on   = 1'b0;
    for (int a = 0; a < 4; a++) rom[a] = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_addr", rom_addr, 0);
    chk("rst_frr", frr, 0);
    chk("rst_data", Data, 0);
    chk("rst_go", go, 0);
    chk("rst_dprst", DpReset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    tick();
    Reset = 1'b0;

    // basic two-word program with halt
    rom[0]   = mkw(0, 0, 8'h55, 6'd3);
    rom[1]   = mkw(0, 1, 8'hA0, 6'd7);
    rom[2]   = mkw(0, 0, 8'hEE, 6'd9);
    rom[3]   = mkw(0, 0, 8'hDD, 6'd8);
    resp_on  = 1'b1;
    resp_dly = 2;
    launch();
    wait_pulse(n);
    chk("lat_go", n, 3);
    chk("go1", go, 1);
    chk("frr1", frr, 3);
    chk("data1", Data, 8'h55);
    wait_pulse(n);
    chk("gap_go", n, 5);
    chk("go2", go, 1);
    chk("frr2", frr, 7);
    chk("data2", Data, 8'hA0);
    wait_end();
    chk("p1_halted", halted, 1);
    chk("p1_addr", rom_addr, 1);

    // datapath reset word needs no ifDone
    rom[0] = mkw(1, 0, 8'h3C, 6'd9);
    launch();
    wait_pulse(n);
    chk("lat_dprst", n, 3);
    chk("dprst", DpReset, 1);
    chk("dprst_nogo", go, 0);
    chk("dprst_frr", frr, 9);
    wait_pulse(n);
    chk("dprst_gap", n, 3);
    chk("dprst_go2", go, 1);
    chk("dprst_frr2", frr, 7);
    wait_end();
    chk("p2_halted", halted, 1);

    // timeout with init ignored while waiting
    rom[0]  = mkw(0, 0, 8'h12, 6'd1);
    rom[1]  = mkw(0, 1, 8'h34, 6'd2);
    resp_on = 1'b0;
    launch();
    wait_pulse(n);
    tick();
    init = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk((k == 5) ? "to_err" : "to_wait", err, (k == 5));
      if (k < 5) begin
        tick();
        if (k == 3) init = 1'b0;
      end
    end
    chk("to_addr", rom_addr, 0);
    resp_on  = 1'b1;
    resp_dly = 1;
    launch();
    @(negedge clk);
    chk("restart", {err, busy, rom_addr}, 4'b0100);
    wait_end();
    chk("p3_halted", halted, 1);

    // stall in WAIT_DONE with ifDone pulse while stalled
    rom[0]  = mkw(0, 0, 8'h11, 6'd5);
    rom[1]  = mkw(0, 1, 8'h22, 6'd6);
    resp_on = 1'b0;
    launch();
    wait_pulse(n);
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      man_done = (i == 2);
      @(negedge clk);
      chk("stall", {busy, go, rom_addr, frr}, {1'b1, 1'b0, 2'd0, 6'd5});
      tick();
    end
    man_done = 1'b0;
    en       = 1'b1;
    resp_on  = 1'b1;
    resp_dly = 1;
    @(negedge clk);
    chk("stall_hold", rom_addr, 0);
    tick();
    @(negedge clk);
    chk("resume", {busy, rom_addr}, 3'b101);
    wait_end();
    chk("p4_halted", halted, 1);

    // reset in the middle of an instruction
    resp_on = 1'b0;
    launch();
    wait_pulse(n);
    tick();
    Reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid",
        {rom_addr, frr, Data, go, DpReset, busy, halted, err}, 0);
    tick();
    Reset    = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_idle",
          {rom_addr, frr, Data, go, DpReset, busy, halted, err}, 0);
    end

    // ifDone on the expiry cycle wins
    for (int a = 0; a < 4; a++) rom[a] = $urandom & 16'hBFFF;
    run_prog(1'b0, 4, "tie");

    // no halt bits: runs to the top address, no wrap
    for (int a = 0; a < 4; a++) rom[a] = $urandom & 16'hBFFF;
    run_prog(1'b0, 0, "nohalt");

    repeat (20) begin
      for (int a = 0; a < 4; a++) rom[a] = 16'($urandom);
      run_prog(1'b1, 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
